// File: rtl/accel_sweep_if.sv
// Bundles the go/status, accelerator and result-memory signals of the sweep controller.
// master = the controller, slave = the surrounding system (top level, accelerator, memory).
interface accel_sweep_if #(
    parameter int ADDR_W = 8
);
    logic              go;
    logic [1:0]        u_last;
    logic [4:0]        v_last;
    logic              acc_start;
    logic [1:0]        acc_U;
    logic [4:0]        acc_V;
    logic              acc_done;
    logic              acc_wr_req;
    logic [20:0]       acc_wr_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [20:0]       mem_wdata;
    logic              busy;
    logic              all_done;
    logic              err_timeout;
    logic              err_wrap;
    logic [ADDR_W:0]   beat_count;

    modport master (
        input  go, u_last, v_last, acc_done, acc_wr_req, acc_wr_data,
        output acc_start, acc_U, acc_V, mem_we, mem_addr, mem_wdata,
               busy, all_done, err_timeout, err_wrap, beat_count
    );

    modport slave (
        output go, u_last, v_last, acc_done, acc_wr_req, acc_wr_data,
        input  acc_start, acc_U, acc_V, mem_we, mem_addr, mem_wdata,
               busy, all_done, err_timeout, err_wrap, beat_count
    );
endinterface

// File: rtl/accel_sweep_controller.sv
// Runs one accelerator job per (U,V) pair, U outer / V inner, streaming every result
// beat into consecutive result-memory addresses; a watchdog aborts a stalled job.
module accel_sweep_controller #(
    parameter int START_CYCLES = 2,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic         clk,
    input  logic         rst,
    accel_sweep_if.master bus
);
    localparam int DATA_W = 21;
    localparam int SC_W   = $clog2(START_CYCLES) + 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        NEXT,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SC_W-1:0]   start_cnt;
    logic [WD_W-1:0]   wd;
    logic [1:0]        u_lim;
    logic [4:0]        v_lim;
    logic [1:0]        u_cur;
    logic [4:0]        v_cur;
    logic              err_timeout;
    logic              accept_go;
    logic              last_pair;
    logic              launch_over;
    logic              wd_expired;
    logic              capture;
    logic              start_c;
    logic              busy_c;
    logic              done_c;

    logic              we_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   beat_count;
    logic              err_wrap;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign accept_go   = (state == IDLE) && bus.go;
    assign last_pair   = (u_cur == u_lim) && (v_cur == v_lim);
    assign launch_over = (start_cnt == SC_W'(START_CYCLES - 1));
    assign wd_expired  = (wd == WD_W'(TIMEOUT));
    assign capture     = bus.acc_wr_req &&
                         ((state == LAUNCH) || (state == WAIT) || (state == NEXT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.go) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                start_c = 1'b1;
                if (launch_over) state_nxt = WAIT;
            end
            WAIT: begin
                // A done arriving on the watchdog's last cycle still completes the job.
                if (bus.acc_done)    state_nxt = NEXT;
                else if (wd_expired) state_nxt = FINISH;
            end
            NEXT: begin
                state_nxt = last_pair ? FINISH : LAUNCH;
            end
            FINISH: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_cnt   <= '0;
            wd          <= '0;
            u_lim       <= '0;
            v_lim       <= '0;
            u_cur       <= '0;
            v_cur       <= '0;
            err_timeout <= 1'b0;
        end else begin
            start_cnt <= (state == LAUNCH) ? start_cnt + 1'b1 : '0;
            wd        <= (state == WAIT) ? wd + 1'b1 : '0;
            if (accept_go) begin
                u_lim       <= bus.u_last;
                v_lim       <= bus.v_last;
                u_cur       <= '0;
                v_cur       <= '0;
                err_timeout <= 1'b0;
            end
            if ((state == WAIT) && !bus.acc_done && wd_expired) begin
                err_timeout <= 1'b1;
            end
            if ((state == NEXT) && !last_pair) begin
                if (v_cur == v_lim) begin
                    v_cur <= '0;
                    u_cur <= u_cur + 1'b1;
                end else begin
                    v_cur <= v_cur + 1'b1;
                end
            end
        end
    end

    // Stage p1: beat sampled at n is written at n+1; address advances after each write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1      <= 1'b0;
            wdata_p1   <= '0;
            addr       <= '0;
            beat_count <= '0;
            err_wrap   <= 1'b0;
        end else begin
            we_p1 <= capture;
            if (capture) begin
                wdata_p1 <= bus.acc_wr_data;
            end
            if (accept_go) begin
                addr       <= '0;
                beat_count <= '0;
                err_wrap   <= 1'b0;
            end else if (we_p1) begin
                addr       <= addr + 1'b1;
                beat_count <= sat_inc(beat_count);
                if (&addr) err_wrap <= 1'b1;
            end
        end
    end

    assign bus.acc_start   = start_c;
    assign bus.acc_U       = u_cur;
    assign bus.acc_V       = v_cur;
    assign bus.mem_we      = we_p1;
    assign bus.mem_addr    = addr;
    assign bus.mem_wdata   = wdata_p1;
    assign bus.busy        = busy_c;
    assign bus.all_done    = done_c;
    assign bus.err_timeout = err_timeout;
    assign bus.err_wrap    = err_wrap;
    assign bus.beat_count  = beat_count;
endmodule

// File: tb/tb_accel_sweep_controller.sv
// Bench for accel_sweep_controller: behavioural accelerator plus a write scoreboard.
// dut_a covers the sweep/timeout/reset scenarios, dut_b (2-bit addresses) the wrap case.
module tb_accel_sweep_controller;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 20;
    localparam int ADDR_A       = 8;
    localparam int ADDR_B       = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [20:0] exp_data_q[$];
    int          exp_addr_q[$];
    int          job_q[$];

    always #5 clk = ~clk;

    accel_sweep_if #(.ADDR_W(ADDR_A)) bus_a();
    accel_sweep_if #(.ADDR_W(ADDR_B)) bus_b();

    accel_sweep_controller #(.START_CYCLES(START_CYCLES), .ADDR_W(ADDR_A), .TIMEOUT(TIMEOUT))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    accel_sweep_controller #(.START_CYCLES(START_CYCLES), .ADDR_W(ADDR_B), .TIMEOUT(TIMEOUT))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input int ul, input int vl, input int beats, input bit done_en,
                             input bit coincide, output int n_starts, output int fall_cyc,
                             output int done_cyc);
        int          start_len = 0;
        bit          prev_start = 1'b0;
        bit          active = 1'b0;
        bit          seen = 1'b0;
        bit          fin = 1'b0;
        int          k = 0;
        int          exp_addr = 0;
        int          job;
        int          ea;
        logic [20:0] ed;
        logic [20:0] d;
        n_starts = 0;
        fall_cyc = -1;
        done_cyc = -1;
        exp_data_q.delete();
        exp_addr_q.delete();
        job_q.delete();
        for (int u = 0; u <= ul; u++)
            for (int v = 0; v <= vl; v++) job_q.push_back(u * 32 + v);
        bus_a.go     = 1'b1;
        bus_a.u_last = 2'(ul);
        bus_a.v_last = 5'(vl);
        step();
        bus_a.go = 1'b0;
        n_tests++;
        if (bus_a.err_timeout !== 1'b0 || bus_a.err_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL go_clears_errors: err_timeout=%0b err_wrap=%0b, expected 0 0",
                     bus_a.err_timeout, bus_a.err_wrap);
        end
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (bus_a.mem_we === 1'b1) begin
                n_tests++;
                if (exp_data_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_write_unexpected: addr=%0d data=%h, expected no write",
                             bus_a.mem_addr, bus_a.mem_wdata);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (bus_a.mem_addr !== 8'(ea) || bus_a.mem_wdata !== ed) begin
                        n_fail++;
                        $display("FAIL mem_write: addr=%0d data=%h, expected addr=%0d data=%h",
                                 bus_a.mem_addr, bus_a.mem_wdata, ea, ed);
                    end
                end
            end
            if (seen) begin
                n_tests++;
                if (bus_a.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_after_finish: busy=%0b, expected 0", bus_a.busy);
                end
                fin = 1'b1;
            end else begin
                if (bus_a.acc_start === 1'b1) begin
                    if (!prev_start) begin
                        n_tests++;
                        if (job_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL extra_job: U=%0d V=%0d, expected no further job",
                                     bus_a.acc_U, bus_a.acc_V);
                        end else begin
                            job = job_q.pop_front();
                            if (bus_a.acc_U !== 2'(job / 32) || bus_a.acc_V !== 5'(job % 32)) begin
                                n_fail++;
                                $display("FAIL job_order: U=%0d V=%0d, expected U=%0d V=%0d",
                                         bus_a.acc_U, bus_a.acc_V, job / 32, job % 32);
                            end
                        end
                    end
                    start_len++;
                end else if (prev_start) begin
                    n_starts++;
                    n_tests++;
                    if (start_len != START_CYCLES) begin
                        n_fail++;
                        $display("FAIL start_length: %0d cycles, expected %0d",
                                 start_len, START_CYCLES);
                    end
                    start_len = 0;
                    active    = 1'b1;
                    k         = 0;
                    fall_cyc  = cyc;
                end
                if (bus_a.all_done === 1'b1) begin
                    seen     = 1'b1;
                    done_cyc = cyc;
                end
            end
            prev_start        = bus_a.acc_start;
            bus_a.acc_wr_req  = 1'b0;
            bus_a.acc_done    = 1'b0;
            if (active && !seen) begin
                if (k < beats) begin
                    d                 = 21'($urandom);
                    bus_a.acc_wr_req  = 1'b1;
                    bus_a.acc_wr_data = d;
                    exp_data_q.push_back(d);
                    exp_addr_q.push_back(exp_addr);
                    exp_addr = (exp_addr + 1) % 256;
                end
                if (done_en && k == (coincide ? beats - 1 : beats)) begin
                    bus_a.acc_done = 1'b1;
                    active         = 1'b0;
                end
                k++;
            end
            if (!fin) step();
        end
        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL sweep_timeout: all_done not seen within budget, expected one pulse");
        end
        n_tests++;
        if (job_q.size() != 0 || exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d jobs and %0d writes outstanding, expected 0 0",
                     job_q.size(), exp_data_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (bus_a.acc_start !== 1'b0 || bus_b.acc_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_start: a=%0b b=%0b, expected 0 0",
                         bus_a.acc_start, bus_b.acc_start);
            end
        end
        n_tests++;
        if ({bus_a.busy, bus_a.all_done, bus_a.mem_we, bus_a.err_timeout, bus_a.err_wrap} !== 5'b0 ||
            bus_a.acc_U !== 2'd0 || bus_a.acc_V !== 5'd0 || bus_a.mem_addr !== 8'd0 ||
            bus_a.mem_wdata !== 21'd0 || bus_a.beat_count !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: busy=%0b done=%0b we=%0b U=%0d V=%0d addr=%0d cnt=%0d, expected all 0",
                     bus_a.busy, bus_a.all_done, bus_a.mem_we, bus_a.acc_U, bus_a.acc_V,
                     bus_a.mem_addr, bus_a.beat_count);
        end
        n_tests++;
        if ({bus_b.busy, bus_b.all_done, bus_b.mem_we, bus_b.err_timeout, bus_b.err_wrap} !== 5'b0 ||
            bus_b.mem_addr !== 2'd0 || bus_b.beat_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_b: busy=%0b we=%0b addr=%0d cnt=%0d, expected all 0",
                     bus_b.busy, bus_b.mem_we, bus_b.mem_addr, bus_b.beat_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_job();
        int ns, fc, dc;
        run_sweep(0, 0, 3, 1'b1, 1'b0, ns, fc, dc);
        n_tests++;
        if (ns != 1 || bus_a.beat_count !== 9'd3) begin
            n_fail++;
            $display("FAIL single_job: starts=%0d beat_count=%0d, expected 1 3", ns, bus_a.beat_count);
        end
    endtask

    task automatic test_multi_job();
        int ns, fc, dc;
        run_sweep(1, 2, 2, 1'b1, 1'b1, ns, fc, dc);
        n_tests++;
        if (ns != 6 || bus_a.beat_count !== 9'd12) begin
            n_fail++;
            $display("FAIL multi_job: starts=%0d beat_count=%0d, expected 6 12", ns, bus_a.beat_count);
        end
        n_tests++;
        if (bus_a.acc_U !== 2'd1 || bus_a.acc_V !== 5'd2) begin
            n_fail++;
            $display("FAIL operands_hold: U=%0d V=%0d, expected 1 2", bus_a.acc_U, bus_a.acc_V);
        end
    endtask

    task automatic test_timeout();
        int ns, fc, dc;
        run_sweep(0, 0, 2, 1'b0, 1'b0, ns, fc, dc);
        n_tests++;
        if (dc - fc != TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: %0d cycles, expected %0d", dc - fc, TIMEOUT + 1);
        end
        n_tests++;
        if (bus_a.err_timeout !== 1'b1 || bus_a.beat_count !== 9'd2) begin
            n_fail++;
            $display("FAIL timeout_flag: err_timeout=%0b beat_count=%0d, expected 1 2",
                     bus_a.err_timeout, bus_a.beat_count);
        end
        step();
        n_tests++;
        if (bus_a.err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err_timeout=%0b, expected 1", bus_a.err_timeout);
        end
        run_sweep(0, 0, 1, 1'b1, 1'b1, ns, fc, dc);
        n_tests++;
        if (bus_a.err_timeout !== 1'b0 || ns != 1) begin
            n_fail++;
            $display("FAIL timeout_cleared: err_timeout=%0b starts=%0d, expected 0 1",
                     bus_a.err_timeout, ns);
        end
    endtask

    task automatic test_reset_mid_job();
        int ns, fc, dc;
        bus_a.go     = 1'b1;
        bus_a.u_last = 2'd1;
        bus_a.v_last = 5'd1;
        step();
        bus_a.go          = 1'b1;
        bus_a.acc_wr_req  = 1'b1;
        bus_a.acc_wr_data = 21'h0ABCDE;
        step();
        bus_a.go         = 1'b0;
        bus_a.acc_wr_req = 1'b0;
        n_tests++;
        if (bus_a.acc_start !== 1'b1 || bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 8'd0 ||
            bus_a.mem_wdata !== 21'h0ABCDE) begin
            n_fail++;
            $display("FAIL launch_beat: start=%0b we=%0b addr=%0d data=%h, expected 1 1 0 0abcde",
                     bus_a.acc_start, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
        end
        step();
        n_tests++;
        if (bus_a.acc_start !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.mem_addr !== 8'd1 ||
            bus_a.beat_count !== 9'd1) begin
            n_fail++;
            $display("FAIL go_in_launch_ignored: start=%0b busy=%0b addr=%0d cnt=%0d, expected 0 1 1 1",
                     bus_a.acc_start, bus_a.busy, bus_a.mem_addr, bus_a.beat_count);
        end
        rst               = 1'b1;
        bus_a.acc_wr_req  = 1'b1;
        bus_a.acc_wr_data = 21'h155555;
        step();
        rst              = 1'b0;
        bus_a.acc_wr_req = 1'b0;
        n_tests++;
        if ({bus_a.busy, bus_a.acc_start, bus_a.all_done, bus_a.mem_we, bus_a.err_timeout,
             bus_a.err_wrap} !== 6'b0 || bus_a.acc_U !== 2'd0 || bus_a.acc_V !== 5'd0 ||
            bus_a.mem_addr !== 8'd0 || bus_a.mem_wdata !== 21'd0 || bus_a.beat_count !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_job: busy=%0b start=%0b we=%0b addr=%0d data=%h cnt=%0d, expected all 0",
                     bus_a.busy, bus_a.acc_start, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata,
                     bus_a.beat_count);
        end
        step();
        n_tests++;
        if (bus_a.mem_we !== 1'b0 || bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discards_beat: we=%0b busy=%0b, expected 0 0",
                     bus_a.mem_we, bus_a.busy);
        end
        run_sweep(0, 0, 2, 1'b1, 1'b0, ns, fc, dc);
        n_tests++;
        if (ns != 1 || bus_a.beat_count !== 9'd2) begin
            n_fail++;
            $display("FAIL restart_after_reset: starts=%0d cnt=%0d, expected 1 2", ns, bus_a.beat_count);
        end
    endtask

    task automatic test_addr_wrap();
        bit          prev_start = 1'b0;
        bit          active = 1'b0;
        int          k = 0;
        int          n_wr = 0;
        int          n_done = 0;
        int          ea;
        logic [20:0] ed;
        logic [20:0] d;
        exp_data_q.delete();
        exp_addr_q.delete();
        bus_b.go     = 1'b1;
        bus_b.u_last = 2'd0;
        bus_b.v_last = 5'd0;
        step();
        bus_b.go = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus_b.mem_we === 1'b1) begin
                n_wr++;
                n_tests++;
                if (exp_data_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_write_unexpected: addr=%0d, expected no write", bus_b.mem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (bus_b.mem_addr !== 2'(ea) || bus_b.mem_wdata !== ed) begin
                        n_fail++;
                        $display("FAIL wrap_write: addr=%0d data=%h, expected addr=%0d data=%h",
                                 bus_b.mem_addr, bus_b.mem_wdata, ea, ed);
                    end
                end
            end
            if (bus_b.all_done === 1'b1) n_done++;
            if (bus_b.acc_start !== 1'b1 && prev_start) active = 1'b1;
            prev_start       = bus_b.acc_start;
            bus_b.acc_wr_req = 1'b0;
            bus_b.acc_done   = 1'b0;
            if (active && k < 5) begin
                d                 = 21'($urandom);
                bus_b.acc_wr_req  = 1'b1;
                bus_b.acc_wr_data = d;
                exp_data_q.push_back(d);
                exp_addr_q.push_back(k % 4);
                if (k == 4) bus_b.acc_done = 1'b1;
                k++;
            end
            step();
        end
        n_tests++;
        if (n_wr != 5 || n_done != 1 || bus_b.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_sweep: writes=%0d all_done=%0d busy=%0b, expected 5 1 0",
                     n_wr, n_done, bus_b.busy);
        end
        n_tests++;
        if (bus_b.err_wrap !== 1'b1 || bus_b.beat_count !== 3'd5 || bus_b.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_flags: err_wrap=%0b beat_count=%0d err_timeout=%0b, expected 1 5 0",
                     bus_b.err_wrap, bus_b.beat_count, bus_b.err_timeout);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus_a.go          = 1'b0;
        bus_a.u_last      = '0;
        bus_a.v_last      = '0;
        bus_a.acc_done    = 1'b0;
        bus_a.acc_wr_req  = 1'b0;
        bus_a.acc_wr_data = '0;
        bus_b.go          = 1'b0;
        bus_b.u_last      = '0;
        bus_b.v_last      = '0;
        bus_b.acc_done    = 1'b0;
        bus_b.acc_wr_req  = 1'b0;
        bus_b.acc_wr_data = '0;
        test_reset();
        test_single_job();
        test_multi_job();
        test_timeout();
        test_reset_mid_job();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
